// File: rtl/encoder_pwm_array.sv
// Quadrature decoder array with per-channel preset, feeding shadowed-duty PWM outputs.
// Define ENCODER_PWM_WRAP_EN for modulo counting; otherwise values saturate at 0 and max.
module encoder_pwm_array #(
  parameter int NUM_CH       = 3,
  parameter int WIDTH        = 8,
  parameter int DEBOUNCE_DIV = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       enc_a,
  input  logic [NUM_CH-1:0]       enc_b,
  input  logic                    load_valid,
  input  logic [2:0]              load_ch,
  input  logic [WIDTH-1:0]        load_value,
  output logic [NUM_CH*WIDTH-1:0] value,
  output logic [NUM_CH-1:0]       pwm_out
);

  localparam logic [15:0]      PRESC_MAX = 16'(DEBOUNCE_DIV - 1);
  localparam logic [WIDTH-1:0] CNT_MAX   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ZERO  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    STEP_NONE = 2'b00,
    STEP_UP   = 2'b01,
    STEP_DN   = 2'b10
  } step_e;

  // Old/new {a,b} pair; single-bit Gray moves give a direction, anything else is no step.
  function automatic step_e decode_step(input logic [1:0] old_ab, input logic [1:0] new_ab);
    case ({old_ab, new_ab})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: decode_step = STEP_UP;
      4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: decode_step = STEP_DN;
      default:                                decode_step = STEP_NONE;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] apply_step(input logic [WIDTH-1:0] v, input step_e st);
    case (st)
`ifdef ENCODER_PWM_WRAP_EN
      STEP_UP: apply_step = v + CNT_ONE;
      STEP_DN: apply_step = v - CNT_ONE;
`else
      STEP_UP: apply_step = (v == CNT_MAX)  ? v : v + CNT_ONE;
      STEP_DN: apply_step = (v == CNT_ZERO) ? v : v - CNT_ONE;
`endif
      default: apply_step = v;
    endcase
  endfunction

  logic [NUM_CH-1:0] a_s1_r, a_s2_r, b_s1_r, b_s2_r;
  logic [NUM_CH-1:0] deb_a_r, deb_b_r;
  logic [15:0]       presc_r;
  logic              strobe_s;
  logic [WIDTH-1:0]  pwm_cnt_r;
  logic [WIDTH-1:0]  value_r     [NUM_CH];
  logic [WIDTH-1:0]  value_nxt_s [NUM_CH];
  logic [WIDTH-1:0]  duty_r      [NUM_CH];
  logic [NUM_CH-1:0] pwm_r;

  assign strobe_s = (presc_r == PRESC_MAX);

  // Synchronisers, sample prescaler and debounced pin state.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_s1_r  <= {NUM_CH{1'b0}};
      a_s2_r  <= {NUM_CH{1'b0}};
      b_s1_r  <= {NUM_CH{1'b0}};
      b_s2_r  <= {NUM_CH{1'b0}};
      deb_a_r <= {NUM_CH{1'b0}};
      deb_b_r <= {NUM_CH{1'b0}};
      presc_r <= 16'd0;
    end else begin
      a_s1_r  <= enc_a;
      a_s2_r  <= a_s1_r;
      b_s1_r  <= enc_b;
      b_s2_r  <= b_s1_r;
      presc_r <= strobe_s ? 16'd0 : presc_r + 16'd1;
      if (strobe_s) begin
        deb_a_r <= a_s2_r;
        deb_b_r <= b_s2_r;
      end
    end
  end

  // Next channel value: a preset on this channel discards a coincident decode step.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      value_nxt_s[i] = value_r[i];
      if (load_valid && (load_ch == 3'(i))) begin
        value_nxt_s[i] = load_value;
      end else if (strobe_s) begin
        value_nxt_s[i] = apply_step(value_r[i],
                                    decode_step({deb_a_r[i], deb_b_r[i]}, {a_s2_r[i], b_s2_r[i]}));
      end else begin
        value_nxt_s[i] = value_r[i];
      end
    end
  end

  // Channel values, PWM counter, duty shadows (reloaded only at period end) and outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt_r <= CNT_ZERO;
      pwm_r     <= {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
        value_r[i] <= CNT_ZERO;
        duty_r[i]  <= CNT_ZERO;
      end
    end else begin
      pwm_cnt_r <= pwm_cnt_r + CNT_ONE;
      for (int i = 0; i < NUM_CH; i++) begin
        value_r[i] <= value_nxt_s[i];
        pwm_r[i]   <= (pwm_cnt_r < duty_r[i]);
        if (pwm_cnt_r == CNT_MAX) begin
          duty_r[i] <= value_r[i];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_value
    assign value[g*WIDTH +: WIDTH] = value_r[g];
  end

  assign pwm_out = pwm_r;

endmodule

// File: tb/tb_encoder_pwm_array.sv
// Scoreboard bench for encoder_pwm_array (NUM_CH=3, WIDTH=8, DEBOUNCE_DIV=4).
`timescale 1ns/1ps
module tb_encoder_pwm_array;

  localparam int NUM_CH  = 3;
  localparam int WIDTH   = 8;
  localparam int DIV     = 4;
  localparam int SEL_PWM = 8;
  localparam int SEL_HI  = 16;
`ifdef ENCODER_PWM_WRAP_EN
  localparam int INC_FROM_MAX  = 0;
  localparam int DEC_FROM_ZERO = 255;
`else
  localparam int INC_FROM_MAX  = 255;
  localparam int DEC_FROM_ZERO = 0;
`endif

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NUM_CH-1:0]       enc_a, enc_b;
  logic                    load_valid;
  logic [2:0]              load_ch;
  logic [WIDTH-1:0]        load_value;
  logic [NUM_CH*WIDTH-1:0] value;
  logic [NUM_CH-1:0]       pwm_out;

  always #5 clk = ~clk;

  encoder_pwm_array #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DEBOUNCE_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .load_valid(load_valid), .load_ch(load_ch), .load_value(load_value),
    .value(value), .pwm_out(pwm_out)
  );

  int checks = 0;
  int errors = 0;
  int presc_m, pwm_m;
  int hi_meas [NUM_CH];

  typedef struct {
    int    sel;
    int    exp;
    string name;
  } item_t;
  item_t sb_q[$];

  // Reference prescaler and PWM counter phase, used only for stimulus timing and period framing.
  always @(posedge clk) begin
    if (reset) begin
      presc_m <= 0;
      pwm_m   <= 0;
    end else begin
      presc_m <= (presc_m == DIV - 1) ? 0 : presc_m + 1;
      pwm_m   <= (pwm_m == 255) ? 0 : pwm_m + 1;
    end
  end

  function automatic int observe(input int sel);
    if (sel < NUM_CH)        return int'(value[sel*WIDTH +: WIDTH]);
    else if (sel == SEL_PWM) return int'(pwm_out);
    else                     return hi_meas[sel - SEL_HI];
  endfunction

  // Monitor: drain pending expectations against the DUT on the falling edge.
  always @(negedge clk) begin : monitor
    item_t it;
    int    got;
    while (sb_q.size() > 0) begin
      it  = sb_q.pop_front();
      got = observe(it.sel);
      checks = checks + 1;
      if (got != it.exp) begin
        errors = errors + 1;
        $display("FAIL %s actual=%0d expected=%0d", it.name, got, it.exp);
      end
    end
  end

  task automatic push_exp(input int sel, input int exp, input string name);
    item_t it;
    it.sel  = sel;
    it.exp  = exp;
    it.name = name;
    sb_q.push_back(it);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic timeout_fail(input string name);
    checks = checks + 1;
    errors = errors + 1;
    $display("FAIL %s actual=timeout expected=event", name);
  endtask

  task automatic set_pins(input int ch, input logic a, input logic b);
    enc_a[ch] = a;
    enc_b[ch] = b;
    tick(8);
  endtask

  task automatic do_load(input int ch, input int v);
    load_ch    = 3'(ch);
    load_value = 8'(v);
    load_valid = 1'b1;
    tick(1);
    load_valid = 1'b0;
  endtask

  task automatic wait_cnt(input int target);
    int n = 0;
    do begin
      tick(1);
      n++;
    end while (pwm_m != target && n < 600);
    if (pwm_m != target) timeout_fail("wait_pwm_cnt");
  endtask

  // Count high cycles per channel up to and including the sample of pwm_cnt=255.
  // from_now=0 starts at the sample of pwm_cnt=0, giving one whole 256-cycle period.
  task automatic measure(input bit from_now);
    int cnt [NUM_CH];
    int n;
    bit started;
    bit done;
    for (int c = 0; c < NUM_CH; c++) cnt[c] = 0;
    started = from_now;
    n = 0;
    while (!started && n < 600) begin
      @(negedge clk);
      n++;
      if (pwm_m == 1) started = 1'b1;
    end
    if (!started) begin
      timeout_fail("measure_start");
    end else begin
      if (from_now) @(negedge clk);
      n = 0;
      do begin
        for (int c = 0; c < NUM_CH; c++) cnt[c] += int'(pwm_out[c]);
        done = (pwm_m == 0);
        if (!done) @(negedge clk);
        n++;
      end while (!done && n < 300);
    end
    for (int c = 0; c < NUM_CH; c++) hi_meas[c] = cnt[c];
  endtask

  initial begin
    reset      = 1'b1;
    enc_a      = '0;
    enc_b      = '0;
    load_valid = 1'b0;
    load_ch    = 3'd0;
    load_value = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    push_exp(0, 0, "rst_v0");
    push_exp(1, 0, "rst_v1");
    push_exp(2, 0, "rst_v2");
    push_exp(SEL_PWM, 0, "rst_pwm");

    // Forward quadrature cycle on ch0, then the reverse.
    set_pins(0, 1'b1, 1'b0); push_exp(0, 1, "fwd_00_10");
    set_pins(0, 1'b1, 1'b1); push_exp(0, 2, "fwd_10_11");
    set_pins(0, 1'b0, 1'b1); push_exp(0, 3, "fwd_11_01");
    set_pins(0, 1'b0, 1'b0); push_exp(0, 4, "fwd_01_00");
    set_pins(0, 1'b0, 1'b1); push_exp(0, 3, "rev_00_01");
    set_pins(0, 1'b1, 1'b1); push_exp(0, 2, "rev_01_11");
    set_pins(0, 1'b1, 1'b0); push_exp(0, 1, "rev_11_10");
    set_pins(0, 1'b0, 1'b0); push_exp(0, 0, "rev_10_00");

    // Boundary behaviour on ch1.
    do_load(1, 255);         push_exp(1, 255, "load_max");
    set_pins(1, 1'b1, 1'b0); push_exp(1, INC_FROM_MAX, "inc_at_max");
    do_load(1, 0);           push_exp(1, 0, "load_zero");
    set_pins(1, 1'b0, 1'b0); push_exp(1, DEC_FROM_ZERO, "dec_at_zero");

    // Out-of-range channel index is ignored.
    do_load(3, 77);
    do_load(5, 88);
    push_exp(0, 0, "bad_ch_v0");
    push_exp(1, DEC_FROM_ZERO, "bad_ch_v1");
    push_exp(2, 0, "bad_ch_v2");

    // Load ch2 on the very strobe edge that steps ch0 and ch2.
    begin : align
      int n = 0;
      do begin
        tick(1);
        n++;
      end while (presc_m != 0 && n < 8);
    end
    enc_a[0] = 1'b1; enc_b[0] = 1'b0;
    enc_a[2] = 1'b1; enc_b[2] = 1'b0;
    tick(3);
    do_load(2, 100);
    tick(4);
    push_exp(0, 1, "coincide_v0_steps");
    push_exp(2, 100, "coincide_v2_load_wins");
    push_exp(1, DEC_FROM_ZERO, "coincide_v1_idle");

    // PWM duty from the first period boundary after a load.
    do_load(0, 64);
    do_load(1, 0);
    tick(2);
    measure(1'b0);
    push_exp(SEL_HI + 0, 64, "pwm_p1_ch0");
    push_exp(SEL_HI + 1, 0, "pwm_p1_ch1_zero");
    push_exp(SEL_HI + 2, 100, "pwm_p1_ch2");
    measure(1'b0);
    push_exp(SEL_HI + 0, 64, "pwm_p2_ch0");
    push_exp(SEL_HI + 1, 0, "pwm_p2_ch1_zero");

    // Value change mid-period only takes effect in the following period.
    do_load(0, 200);
    tick(2);
    measure(1'b0);
    push_exp(SEL_HI + 0, 200, "pwm_duty200");
    fork
      measure(1'b0);
      begin
        wait_cnt(100);
        do_load(0, 32);
      end
    join
    push_exp(SEL_HI + 0, 200, "pwm_midchange_cur");
    push_exp(0, 32, "midchange_value");
    measure(1'b0);
    push_exp(SEL_HI + 0, 32, "pwm_midchange_next");

    // Park pins at ch0=11, ch2=00, then reset mid-period.
    set_pins(0, 1'b1, 1'b1); push_exp(0, 33, "ch0_10_11");
    set_pins(2, 1'b0, 1'b0); push_exp(2, 99, "ch2_10_00");
    do_load(0, 50);
    wait_cnt(0);
    wait_cnt(20);
    push_exp(SEL_PWM, 5, "pre_reset_pwm");
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    push_exp(0, 0, "post_rst_v0");
    push_exp(2, 0, "post_rst_v2");
    push_exp(SEL_PWM, 0, "post_rst_pwm");
    tick(8);
    push_exp(0, 0, "rst_pins11_no_step");
    push_exp(2, 0, "rst_pins00_no_step");
    do_load(0, 50);
    measure(1'b1);
    push_exp(SEL_HI + 0, 0, "first_period_duty0");
    measure(1'b0);
    push_exp(SEL_HI + 0, 50, "second_period_ch0");
    push_exp(SEL_HI + 2, 0, "second_period_ch2");

    // Two-bit glitches never step.
    set_pins(0, 1'b0, 1'b0); push_exp(0, 50, "glitch_11_00");
    set_pins(0, 1'b1, 1'b1); push_exp(0, 50, "glitch_00_11");

    tick(2);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/encoder_pwm_array.md
ENCODER_PWM_ARRAY -- requirements
Module: encoder_pwm_array

Interface
REQ-001 Parameter NUM_CH, default 3: number of encoder/PWM channels, range 1..8.
REQ-002 Parameter WIDTH, default 8: bits per channel value, duty and PWM counter, range 4..12.
REQ-003 Parameter DEBOUNCE_DIV, default 16: encoder sample period in clk cycles, range 1..65535.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enc_a  input  NUM_CH  quadrature phase A per channel, asynchronous to clk.
REQ-007 enc_b  input  NUM_CH  quadrature phase B per channel, asynchronous to clk.
REQ-008 load_valid  input  1  single-cycle preset strobe.
REQ-009 load_ch  input  3  channel index for the preset; an index >= NUM_CH is ignored.
REQ-010 load_value  input  WIDTH  preset value.
REQ-011 value  output  NUM_CH*WIDTH  channel values, channel i at bits [i*WIDTH +: WIDTH].
REQ-012 pwm_out  output  NUM_CH  registered PWM output per channel.

Function
REQ-013 Each enc_a/enc_b bit SHALL pass through a two-flop synchroniser (s1, s2) before any other use.
REQ-014 A prescaler SHALL count 0..DEBOUNCE_DIV-1 and wrap; strobe is high in the cycle the count equals DEBOUNCE_DIV-1; with DEBOUNCE_DIV=1 strobe is high every cycle.
REQ-015 On strobe, per channel: the sampled state deb{a,b} <= s2{a,b}, and the old-to-new pair is decoded in the same edge.
REQ-016 Transitions 00->10, 10->11, 11->01, 01->00 SHALL increment value by 1; the reverse transitions SHALL decrement by 1.
REQ-017 No change and two-bit changes (00<->11, 10<->01) SHALL leave value unchanged.
REQ-018 Pin-change-to-value latency: 2 cycles (synchroniser) plus wait to the next strobe; value updates on that strobe edge.
REQ-019 Counter arithmetic is WIDTH bits unsigned; boundary behaviour per REQ-029/REQ-030.
REQ-020 load_valid with a valid load_ch SHALL write load_value to that channel on the same edge; if a decode step hits the same channel on the same edge, the load wins and the step is discarded; other channels step normally.
REQ-021 A free-running WIDTH-bit pwm_cnt SHALL count 0..2^WIDTH-1 and wrap to 0.
REQ-022 Per channel, duty shadow SHALL copy value on the edge where pwm_cnt equals 2^WIDTH-1, so a period is never altered mid-way.
REQ-023 pwm_out[i] <= (pwm_cnt < duty[i]); duty 0 gives constant low, duty 2^WIDTH-1 gives high for 2^WIDTH-1 of 2^WIDTH cycles.

Reset
REQ-024 While reset is high on an edge: s1, s2, deb, prescaler, pwm_cnt, all values, all duty shadows and pwm_out SHALL become 0.
REQ-025 Reset SHALL override load_valid and any decode step on the same edge.
REQ-026 After reset deasserts, deb starts at 00; if the pins rest at 11, the first strobe sees a two-bit change and SHALL NOT step.
REQ-027 Reset mid-period SHALL restart the PWM period from pwm_cnt=0 with duty 0 until the first wrap.

Configuration
REQ-028 Macro ENCODER_PWM_WRAP_EN selects counter boundary behaviour for all channels.
REQ-029 Defined: value wraps modulo 2^WIDTH (max +1 -> 0, 0 -1 -> max).
REQ-030 Undefined: value saturates (max +1 stays max, 0 -1 stays 0); load_value is written unchanged in both modes.

Verification
REQ-031 WIDTH=8, DEBOUNCE_DIV=4, ch0 driven 00->10->11->01->00 with each state held 8 cycles -> value[7:0]=4; reversing the sequence -> returns to 0.
REQ-032 Load ch1=255, then one increment step on ch1 -> with ENCODER_PWM_WRAP_EN value=0; without it value=255; a decrement from load 0 -> 255 / 0 respectively.
REQ-033 load_valid ch2=100 on the same edge as a ch2 increment and a ch0 increment -> ch2=100, ch0=+1.
REQ-034 Load ch0=64, observe two full periods -> pwm_out[0] high exactly 64 of 256 cycles per period starting at the first period boundary; duty 0 -> never high.
REQ-035 Change value mid-period (load 32 at pwm_cnt=100 while duty=200) -> current period stays 200 high cycles, next period 32.
REQ-036 Assert reset for 1 cycle mid-operation with value=50 -> all values 0, pwm_out 0 next cycle, pwm_cnt restarts at 0; 00<->11 glitch on ch0 -> no step.
